rv_miss_resrv_chain: RTL and testbench

Next-generation miss status holding register (MSHR) for a cache bank, extending the flat miss-reservation table with per-entry chaining. Secondary misses to a line already outstanding link behind it and are flagged as pending, so no duplicate memory request is issued. A fill then replays the whole chain in order, one entry per cycle. The block also tracks occupancy and exposes almost-full and empty status so the bank pipeline can throttle early.

---
 rtl/rv_miss_resrv_chain.sv | 147 ++++++++++++++
 tb/tb_rv_miss_resrv_chain.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_miss_resrv_chain.sv
// Miss status holding register with per-entry chaining of secondary misses.
// A fill replays the whole chain for its line in allocation order, one entry per cycle.
module rv_miss_resrv_chain #(
    parameter int MSHR_SIZE       = 8,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int DATA_WIDTH      = 64,
    parameter int ALM_FULL        = MSHR_SIZE - 1,
    parameter int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       allocate_valid,
    output logic                       allocate_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] allocate_addr,
    input  logic [DATA_WIDTH-1:0]      allocate_data,
    output logic [MSHR_ADDR_WIDTH-1:0] allocate_id,
    output logic                       allocate_pending,

    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [MSHR_ADDR_WIDTH-1:0] fill_id,
    output logic [LINE_ADDR_WIDTH-1:0] fill_addr,

    output logic                       dequeue_valid,
    input  logic                       dequeue_ready,
    output logic [MSHR_ADDR_WIDTH-1:0] dequeue_id,
    output logic [LINE_ADDR_WIDTH-1:0] dequeue_addr,
    output logic [DATA_WIDTH-1:0]      dequeue_data,

    output logic [MSHR_ADDR_WIDTH:0]   count,
    output logic                       almost_full,
    output logic                       empty
);
    localparam int CNT_W = MSHR_ADDR_WIDTH + 1;
    typedef logic [MSHR_ADDR_WIDTH-1:0] idx_t;

    logic [MSHR_SIZE-1:0]       valid_q;
    logic [MSHR_SIZE-1:0]       next_valid_q;
    idx_t                       next_idx_q [MSHR_SIZE];
    logic [LINE_ADDR_WIDTH-1:0] addr_q     [MSHR_SIZE];
    logic [DATA_WIDTH-1:0]      data_q     [MSHR_SIZE];

    logic                       deq_valid_q;
    idx_t                       deq_id_q;
    logic [CNT_W-1:0]           count_q;

    idx_t free_idx;
    idx_t tail_idx;
    logic tail_hit;
    logic alloc_fire;
    logic fill_fire;
    logic deq_fire;
    logic link_now;

    // Lowest-index free entry: scan downward so the smallest index wins.
    always_comb begin
        free_idx = '0;
        for (int i = MSHR_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = idx_t'(i);
        end
    end

    // At most one valid entry per line has no successor, so this match is unique.
    always_comb begin
        tail_hit = 1'b0;
        tail_idx = '0;
        for (int i = 0; i < MSHR_SIZE; i++) begin
            if (valid_q[i] && !next_valid_q[i] && addr_q[i] == allocate_addr) begin
                tail_hit = 1'b1;
                tail_idx = idx_t'(i);
            end
        end
    end

    assign allocate_ready   = ~&valid_q;
    assign allocate_id      = free_idx;
    assign allocate_pending = tail_hit;
    assign fill_ready       = ~deq_valid_q;
    assign fill_addr        = addr_q[fill_id];

    assign alloc_fire = allocate_valid & allocate_ready;
    assign fill_fire  = fill_valid & fill_ready;
    assign deq_fire   = deq_valid_q & dequeue_ready;
    // A new miss linking behind the entry leaving this cycle extends the replay.
    assign link_now   = alloc_fire & tail_hit & (tail_idx == deq_id_q);

    assign dequeue_valid = deq_valid_q;
    assign dequeue_id    = deq_id_q;
    assign dequeue_addr  = addr_q[deq_id_q];
    assign dequeue_data  = data_q[deq_id_q];

    assign count       = count_q;
    assign almost_full = count_q >= CNT_W'(ALM_FULL);
    assign empty       = count_q == '0;

    // NOTE: payload and link index are left out of reset; they are only read
    // when the matching valid/next_valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            addr_q[free_idx] <= allocate_addr;
            data_q[free_idx] <= allocate_data;
            if (tail_hit) next_idx_q[tail_idx] <= free_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            next_valid_q <= '0;
            deq_valid_q  <= 1'b0;
            deq_id_q     <= '0;
            count_q      <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[free_idx]      <= 1'b1;
                next_valid_q[free_idx] <= 1'b0;
                if (tail_hit) next_valid_q[tail_idx] <= 1'b1;
            end

            // Placed after the allocate update so a departing entry never keeps a stale link.
            if (deq_fire) begin
                valid_q[deq_id_q]      <= 1'b0;
                next_valid_q[deq_id_q] <= 1'b0;
            end

            if (fill_fire) begin
                deq_valid_q <= 1'b1;
                deq_id_q    <= fill_id;
            end else if (deq_fire) begin
                if (next_valid_q[deq_id_q]) begin
                    deq_id_q <= next_idx_q[deq_id_q];
                end else if (link_now) begin
                    deq_id_q <= free_idx;
                end else begin
                    deq_valid_q <= 1'b0;
                end
            end

            case ({alloc_fire, deq_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_miss_resrv_chain.sv
// Scoreboard bench: a table model predicts status outputs and pushes expected replays on fill.
module tb_rv_miss_resrv_chain;
    localparam int N   = 8;
    localparam int AW  = 26;
    localparam int DW  = 64;
    localparam int IW  = 3;
    localparam int ALM = N - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          allocate_valid;
    logic          allocate_ready;
    logic [AW-1:0] allocate_addr;
    logic [DW-1:0] allocate_data;
    logic [IW-1:0] allocate_id;
    logic          allocate_pending;
    logic          fill_valid;
    logic          fill_ready;
    logic [IW-1:0] fill_id;
    logic [AW-1:0] fill_addr;
    logic          dequeue_valid;
    logic          dequeue_ready;
    logic [IW-1:0] dequeue_id;
    logic [AW-1:0] dequeue_addr;
    logic [DW-1:0] dequeue_data;
    logic [IW:0]   count;
    logic          almost_full;
    logic          empty;

    rv_miss_resrv_chain #(
        .MSHR_SIZE(N), .LINE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALM_FULL(ALM), .MSHR_ADDR_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset),
        .allocate_valid(allocate_valid), .allocate_ready(allocate_ready),
        .allocate_addr(allocate_addr), .allocate_data(allocate_data),
        .allocate_id(allocate_id), .allocate_pending(allocate_pending),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_id(fill_id), .fill_addr(fill_addr),
        .dequeue_valid(dequeue_valid), .dequeue_ready(dequeue_ready), .dequeue_id(dequeue_id),
        .dequeue_addr(dequeue_addr), .dequeue_data(dequeue_data),
        .count(count), .almost_full(almost_full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    bit            m_valid [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_data  [N];
    int            order[$];
    exp_t          sb[$];
    bit            m_deq_valid;
    bit            replay_active;
    logic [AW-1:0] replay_addr;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then advance the model to the next rising edge.
    task automatic cycle();
        int   exp_id;
        int   n;
        int   head;
        bit   exp_ready;
        bit   exp_pend;
        bit   alloc_fire;
        bit   fill_fire;
        bit   deq_fire;
        exp_t e;
        @(negedge clk);
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            order.delete();
            sb.delete();
            m_deq_valid   = 1'b0;
            replay_active = 1'b0;
        end else begin
            exp_id    = 0;
            exp_ready = 1'b0;
            exp_pend  = 1'b0;
            n         = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (!m_valid[i]) begin
                    exp_ready = 1'b1;
                    exp_id    = i;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_valid[i]) n++;
                if (m_valid[i] && m_addr[i] == allocate_addr) exp_pend = 1'b1;
            end

            check("allocate_ready", allocate_ready, exp_ready);
            if (exp_ready) check("allocate_id", allocate_id, exp_id);
            check("allocate_pending", allocate_pending, exp_pend);
            check("fill_ready", fill_ready, !m_deq_valid);
            check("count", count, n);
            check("empty", empty, n == 0);
            check("almost_full", almost_full, n >= ALM);
            check("dequeue_valid", dequeue_valid, m_deq_valid);
            if (m_deq_valid && sb.size() > 0) begin
                check("dequeue_id", dequeue_id, sb[0].id);
                check("dequeue_addr", dequeue_addr, sb[0].addr);
                check("dequeue_data", dequeue_data, sb[0].data);
            end
            if (fill_valid) check("fill_addr", fill_addr, m_addr[fill_id]);

            alloc_fire = allocate_valid && exp_ready;
            fill_fire  = fill_valid && !m_deq_valid;
            deq_fire   = m_deq_valid && dequeue_ready;

            if (fill_fire) begin
                head = -1;
                foreach (order[k]) begin
                    if (head < 0 && m_valid[order[k]] && m_addr[order[k]] == m_addr[fill_id]) head = order[k];
                end
                check("fill_is_head", head, fill_id);
                replay_addr   = m_addr[fill_id];
                replay_active = 1'b1;
                foreach (order[k]) begin
                    if (m_valid[order[k]] && m_addr[order[k]] == replay_addr) begin
                        e.id = order[k]; e.addr = m_addr[order[k]]; e.data = m_data[order[k]];
                        sb.push_back(e);
                    end
                end
            end

            if (alloc_fire) begin
                if (exp_pend && replay_active && allocate_addr == replay_addr) begin
                    e.id = exp_id; e.addr = allocate_addr; e.data = allocate_data;
                    sb.push_back(e);
                end
                m_valid[exp_id] = 1'b1;
                m_addr[exp_id]  = allocate_addr;
                m_data[exp_id]  = allocate_data;
                order.push_back(exp_id);
            end

            if (deq_fire && sb.size() > 0) begin
                e = sb.pop_front();
                m_valid[e.id] = 1'b0;
                for (int k = order.size() - 1; k >= 0; k--) begin
                    if (order[k] == e.id) order.delete(k);
                end
            end

            m_deq_valid = sb.size() > 0;
            if (!m_deq_valid) replay_active = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_alloc(input logic [AW-1:0] a);
        allocate_valid = 1'b1;
        allocate_addr  = a;
        allocate_data  = {$urandom, $urandom};
        cycle();
        allocate_valid = 1'b0;
    endtask

    task automatic do_fill(input int id);
        fill_valid = 1'b1;
        fill_id    = IW'(id);
        cycle();
        fill_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 40;
        dequeue_ready = 1'b1;
        while (m_deq_valid && budget > 0) begin
            cycle();
            budget--;
        end
        if (m_deq_valid) check("drain_timeout", 1, 0);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        allocate_valid = 1'b0;
        allocate_addr  = '0;
        allocate_data  = '0;
        fill_valid     = 1'b0;
        fill_id        = '0;
        dequeue_ready  = 1'b1;
        cycle();
        do_reset();
        check("reset_dequeue_id", dequeue_id, 0);

        // Fill the table with distinct lines, then free one entry while full.
        for (int i = 0; i < N; i++) do_alloc(AW'(32'h10 + i));
        cycle();
        do_fill(3);
        allocate_valid = 1'b1;
        allocate_addr  = 26'h50;
        allocate_data  = 64'h5050_5050_0000_0003;
        cycle();
        cycle();
        allocate_valid = 1'b0;
        cycle();

        // Chain of three misses to line A around an unrelated line B.
        do_reset();
        do_alloc(26'h40);
        do_alloc(26'h41);
        do_alloc(26'h40);
        do_alloc(26'h40);
        do_fill(0);
        drain();

        // Stalled replay of B's chain: payload must hold while dequeue_ready is low.
        do_alloc(26'h41);
        do_alloc(26'h41);
        dequeue_ready = 1'b0;
        do_fill(1);
        repeat (3) cycle();
        drain();

        // Allocate to the line whose tail (entry 5) is leaving this cycle.
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(AW'(32'h20 + i));
        do_alloc(26'h60);
        do_fill(5);
        dequeue_ready = 1'b1;
        do_alloc(26'h60);
        drain();

        // Reset in the middle of a four-entry replay.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(26'h70);
        do_fill(0);
        cycle();
        cycle();
        dequeue_ready = 1'b0;
        do_reset();
        cycle();
        do_alloc(26'h80);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
